tile_accum_sched: RTL and testbench
===================================

Name: tile_accum_sched

Overview:
- Sequences the 16-PE array and the two-stage 16-input tree adder to compute one dot product longer than 16 taps.
- The dot product is split into 1..MAX_TILES tiles of 16 products each; the block issues tiles, accumulates the returned tree sums, adds bias, saturates and applies optional ReLU.
- Sits between the layer controller (start/result handshake) and the PE/tree-adder datapath (tile request, tree valid, tree sum return) in the ECG classifier inference path.

Parameters:
- DATA_WIDTH, 16, width of operands, tree sums, bias and result (signed, common fixed-point format).
- ACC_WIDTH, 32, internal accumulator width; must be >= DATA_WIDTH + clog2(MAX_TILES) + 1.
- MAX_TILES, 16, maximum tiles per dot product.
- TILE_W, 5, width of tile count/index; equals clog2(MAX_TILES+1).
- TREE_LAT, 2, cycles from tree valid-in to sum valid-out.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a dot product; sampled only in IDLE.
- num_tiles  in  TILE_W  tile count, sampled with start.
- bias  in  DATA_WIDTH  signed bias, sampled with start.
- relu_en  in  1  clamp negative results to 0; sampled with start.
- busy  out  1  high in every state except IDLE.
- tile_req  out  1  request that the operand fetch present tile tile_idx to the PEs.
- tile_idx  out  TILE_W  index of the requested tile, 0..num_tiles-1.
- tile_gnt  in  1  PE products for tile_idx are valid this cycle.
- tree_valid  out  1  combinational tile_req & tile_gnt; drives the tree adder valid input.
- sum_in  in  DATA_WIDTH  signed tree adder output.
- sum_valid  in  1  sum_in valid; arrives TREE_LAT cycles after tree_valid.
- result  out  DATA_WIDTH  final signed result.
- result_valid  out  1  result available; held until accepted.
- result_ready  in  1  consumer accepts result when result_valid & result_ready.
- err  out  1  sticky protocol error; cleared by an accepted start.

Behaviour:
- Reset (asynchronous, any state, including mid-operation): state IDLE; busy, tile_req, tile_idx, result, result_valid, err, accumulator and counters all 0. In-flight tree sums are discarded.
- States: IDLE, ISSUE, DRAIN, FINAL, OUT.
- IDLE:
  - start=1 latches num_tiles, bias and relu_en; clears acc, issue count, receive count and err.
  - num_tiles=0 goes to FINAL (result = sat(bias)); otherwise goes to ISSUE.
  - start is ignored in every other state.
- ISSUE:
  - tile_req=1, tile_idx = issue count.
  - On tile_gnt, issue count increments; when the last tile is granted, go to DRAIN.
  - tile_req stays high while waiting for tile_gnt; back-to-back grants are legal.
- Accumulate (ISSUE and DRAIN): on each sum_valid, acc += sign-extended sum_in and receive count increments.
- DRAIN: tile_req=0; when the sum_valid for the final tile arrives, go to FINAL.
- FINAL (one cycle):
  - result <= sat(acc + sign-extended bias), then ReLU if enabled; result_valid <= 1; go to OUT.
  - sat clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- OUT:
  - result and result_valid are held stable until result_ready.
  - On acceptance: result_valid <= 0, go to IDLE. result keeps its last value.
- Protocol errors: sum_valid while receive count == issue count, or sum_valid in IDLE/FINAL/OUT, sets err=1 and that sum is not accumulated.
- num_tiles > MAX_TILES: clamped to MAX_TILES at latch.
- Latency with tile_gnt tied to 1: start in cycle 0, tiles issued in cycles 1..N, result_valid first high in cycle N+TREE_LAT+2.
- A tile_gnt outside ISSUE has no effect.

Decomposition:
- Shared package holds:
  - the state enum;
  - DATA_WIDTH, ACC_WIDTH and TREE_LAT defaults;
  - a saturate-to-DATA_WIDTH function, reused by other layer blocks.
- One natural sub-module: sat_relu (combinational saturate plus optional ReLU), instantiated in FINAL.
- The counters and FSM stay in the top module.

Test Plan:
- N=4, gnt=1, model the tree with TREE_LAT=2, sums 100, -20, 5, 15, bias 10, relu off -> result 110, result_valid first high in cycle 8, busy high in cycles 1..8.
- N=3, gnt low for 2 cycles before each grant -> tile_req holds with tile_idx stable at 0, 1, 2 in turn; result equals the sum of the returned tree values plus bias.
- N=2, sums 30000, 30000, bias 0 -> result 32767. Then sums -30000, -30000, relu_en=1 -> result 0.
- num_tiles=0, bias -7 -> no tile_req ever; result -7 valid in cycle 2. With result_ready held low for 5 cycles, result stays valid and stable, and start pulses during that time are ignored.
- Extra sum_valid in IDLE, plus a duplicate sum after the final tile -> err=1 and result not corrupted; the next accepted start clears err.
- rst_n asserted in DRAIN with one sum outstanding -> all outputs 0 immediately. After release, a stale sum_valid sets err; a new start then runs N=1, sum 42, bias 0 -> result 42.

Source files
------------

// File: rtl/tile_accum_sched_pkg.sv
// -----------------------------------------------------------------------------
// tile_accum_sched_pkg
// Shared definitions for the tiled dot-product scheduler: default widths,
// FSM state encodings and the saturate-to-DATA_WIDTH helper that other layer
// blocks reuse.
// -----------------------------------------------------------------------------
package tile_accum_sched_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int ACC_WIDTH  = 32;
    localparam int MAX_TILES  = 16;
    localparam int TILE_W     = 5;
    localparam int TREE_LAT   = 2;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_ISSUE = 3'd1;
    localparam state_t ST_DRAIN = 3'd2;
    localparam state_t ST_FINAL = 3'd3;
    localparam state_t ST_OUT   = 3'd4;

    // Clamp a wide signed accumulator value into the signed DATA_WIDTH range.
    function automatic logic signed [DATA_WIDTH-1:0] sat_data(
        input logic signed [ACC_WIDTH-1:0] x
    );
        logic signed [ACC_WIDTH-1:0] hi;
        logic signed [ACC_WIDTH-1:0] lo;
        hi = {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
        lo = {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
        if (x > hi) begin
            return hi[DATA_WIDTH-1:0];
        end else if (x < lo) begin
            return lo[DATA_WIDTH-1:0];
        end
        return x[DATA_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/tile_accum_sched_if.sv
// -----------------------------------------------------------------------------
// tile_accum_sched_if
// Bundles the layer-controller handshake (start/result) and the PE/tree-adder
// datapath handshake (tile request/grant, tree valid, sum return).
//   slave  : scheduler view (drives busy, tile_req/idx, tree_valid, result, err)
//   master : environment view (drives start/config, tile_gnt, sums, result_ready)
// -----------------------------------------------------------------------------
interface tile_accum_sched_if #(
    parameter int DATA_WIDTH = tile_accum_sched_pkg::DATA_WIDTH,
    parameter int TILE_W     = tile_accum_sched_pkg::TILE_W
) ();
    import tile_accum_sched_pkg::*;

    logic                         start;
    logic [TILE_W-1:0]            num_tiles;
    logic signed [DATA_WIDTH-1:0] bias;
    logic                         relu_en;
    logic                         busy;
    logic                         tile_req;
    logic [TILE_W-1:0]            tile_idx;
    logic                         tile_gnt;
    logic                         tree_valid;
    logic signed [DATA_WIDTH-1:0] sum_in;
    logic                         sum_valid;
    logic signed [DATA_WIDTH-1:0] result;
    logic                         result_valid;
    logic                         result_ready;
    logic                         err;

    modport slave (
        input  start, num_tiles, bias, relu_en, tile_gnt, sum_in, sum_valid, result_ready,
        output busy, tile_req, tile_idx, tree_valid, result, result_valid, err
    );

    modport master (
        output start, num_tiles, bias, relu_en, tile_gnt, sum_in, sum_valid, result_ready,
        input  busy, tile_req, tile_idx, tree_valid, result, result_valid, err
    );

endinterface

// File: rtl/tile_accum_sched_sat_relu.sv
// -----------------------------------------------------------------------------
// tile_accum_sched_sat_relu
// Combinational saturation of the biased accumulator to DATA_WIDTH followed by
// an optional ReLU clamp.
//   value   in  ACC_WIDTH   signed accumulator + bias
//   relu_en in  1           force negative results to zero
//   result  out DATA_WIDTH  saturated (and rectified) result
// -----------------------------------------------------------------------------
module tile_accum_sched_sat_relu
    import tile_accum_sched_pkg::*;
(
    input  logic signed [ACC_WIDTH-1:0]  value,
    input  logic                         relu_en,
    output logic signed [DATA_WIDTH-1:0] result
);

    logic signed [DATA_WIDTH-1:0] sat;

    always_comb begin
        sat    = sat_data(value);
        result = (relu_en && sat[DATA_WIDTH-1]) ? '0 : sat;
    end

endmodule

// File: rtl/tile_accum_sched.sv
// -----------------------------------------------------------------------------
// tile_accum_sched
// Splits a long dot product into 1..MAX_TILES tiles of 16 products, requests
// each tile from the PE array, accumulates the tree-adder sums, adds bias,
// saturates, optionally rectifies and presents the result with a valid/ready
// handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : tile_accum_sched_if.slave (controller + datapath handshakes)
// -----------------------------------------------------------------------------
module tile_accum_sched #(
    parameter int DATA_WIDTH = tile_accum_sched_pkg::DATA_WIDTH,
    parameter int ACC_WIDTH  = tile_accum_sched_pkg::ACC_WIDTH,
    parameter int MAX_TILES  = tile_accum_sched_pkg::MAX_TILES,
    parameter int TILE_W     = tile_accum_sched_pkg::TILE_W
) (
    input logic               clk,
    input logic               rst_n,
    tile_accum_sched_if.slave bus
);
    import tile_accum_sched_pkg::*;

    state_t                       state;
    logic [TILE_W-1:0]            n_tiles;
    logic [TILE_W-1:0]            issue_cnt;
    logic [TILE_W-1:0]            recv_cnt;
    logic [TILE_W-1:0]            n_clamped;
    logic signed [DATA_WIDTH-1:0] bias_q;
    logic                         relu_q;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [ACC_WIDTH-1:0]  sum_ext;
    logic signed [ACC_WIDTH-1:0]  final_sum;
    logic signed [DATA_WIDTH-1:0] final_res;
    logic signed [DATA_WIDTH-1:0] result_q;
    logic                         result_valid_q;
    logic                         err_q;
    logic                         in_accum;
    logic                         sum_ok;
    logic                         sum_err;
    logic                         last_grant;
    logic                         last_sum;

    assign bus.busy         = (state != ST_IDLE);
    assign bus.tile_req     = (state == ST_ISSUE);
    assign bus.tile_idx     = bus.tile_req ? issue_cnt : '0;
    assign bus.tree_valid   = bus.tile_req & bus.tile_gnt;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.err          = err_q;

    assign n_clamped = (bus.num_tiles > TILE_W'(MAX_TILES)) ? TILE_W'(MAX_TILES) : bus.num_tiles;

    // A sum is only legitimate while some issued tile is still unanswered.
    assign in_accum   = (state == ST_ISSUE) || (state == ST_DRAIN);
    assign sum_ok     = bus.sum_valid && in_accum && (recv_cnt != issue_cnt);
    assign sum_err    = bus.sum_valid && !sum_ok;
    assign sum_ext    = ACC_WIDTH'(bus.sum_in);
    assign last_grant = bus.tree_valid && ((issue_cnt + TILE_W'(1)) == n_tiles);
    assign last_sum   = sum_ok && ((recv_cnt + TILE_W'(1)) == n_tiles);
    assign final_sum  = acc + ACC_WIDTH'(bias_q);

    tile_accum_sched_sat_relu u_sat_relu (
        .value   (final_sum),
        .relu_en (relu_q),
        .result  (final_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            n_tiles        <= '0;
            issue_cnt      <= '0;
            recv_cnt       <= '0;
            bias_q         <= '0;
            relu_q         <= 1'b0;
            acc            <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            if (sum_ok) begin
                acc      <= acc + sum_ext;
                recv_cnt <= recv_cnt + TILE_W'(1);
            end
            if (bus.tree_valid) begin
                issue_cnt <= issue_cnt + TILE_W'(1);
            end
            if (sum_err) begin
                err_q <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        n_tiles   <= n_clamped;
                        bias_q    <= bus.bias;
                        relu_q    <= bus.relu_en;
                        acc       <= '0;
                        issue_cnt <= '0;
                        recv_cnt  <= '0;
                        // A stray sum in the same cycle still flags an error.
                        err_q     <= sum_err;
                        state     <= (n_clamped == '0) ? ST_FINAL : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (last_grant) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (last_sum) begin
                        state <= ST_FINAL;
                    end
                end
                ST_FINAL: begin
                    result_q       <= final_res;
                    result_valid_q <= 1'b1;
                    state          <= ST_OUT;
                end
                ST_OUT: begin
                    if (bus.result_ready) begin
                        result_valid_q <= 1'b0;
                        state          <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_accum_sched.sv
module tb_tile_accum_sched;
    import tile_accum_sched_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic signed [DATA_WIDTH-1:0] tile_sums [MAX_TILES];
    logic signed [DATA_WIDTH-1:0] exp_q [$];

    // tree adder model state (owned by tree_model) and injection requests
    logic                         pend_v = 1'b0;
    logic signed [DATA_WIDTH-1:0] pend_d = '0;
    int                           extra_req  = 0;
    int                           extra_done = 0;
    logic signed [DATA_WIDTH-1:0] extra_d = '0;

    always #5 clk = ~clk;

    tile_accum_sched_if bus ();

    tile_accum_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Tree adder: tree_valid seen in cycle k yields sum_valid in cycle k+2.
    always begin : tree_model
        logic              tv;
        logic [TILE_W-1:0] ti;
        @(negedge clk);
        tv = bus.tree_valid;
        ti = bus.tile_idx;
        @(posedge clk);
        #1;
        if (pend_v) begin
            bus.sum_valid = 1'b1;
            bus.sum_in    = pend_d;
        end else if (extra_req != extra_done) begin
            bus.sum_valid = 1'b1;
            bus.sum_in    = extra_d;
            extra_done++;
        end else begin
            bus.sum_valid = 1'b0;
            bus.sum_in    = '0;
        end
        pend_v = tv;
        pend_d = tile_sums[int'(ti) % MAX_TILES];
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input int n, input logic signed [DATA_WIDTH-1:0] b, input logic r);
        bus.start     = 1'b1;
        bus.num_tiles = TILE_W'(n);
        bus.bias      = b;
        bus.relu_en   = r;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_result(input int budget, output int waited, output bit ok);
        waited = 0;
        while (bus.result_valid !== 1'b1 && waited < budget) begin
            tick();
            waited++;
        end
        ok = (bus.result_valid === 1'b1);
    endtask

    task automatic run_one(input int n, input logic signed [DATA_WIDTH-1:0] b, input logic r,
                           output logic signed [DATA_WIDTH-1:0] got, output bit ok);
        int w;
        bus.tile_gnt     = 1'b1;
        bus.result_ready = 1'b1;
        start_op(n, b, r);
        wait_result(40, w, ok);
        got = bus.result;
        tick();
        bus.tile_gnt = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_tests++; if (bus.tile_req !== 1'b0) begin n_fail++; $display("FAIL reset_tile_req: got %b want 0", bus.tile_req); end
        n_tests++; if (bus.tile_idx !== '0) begin n_fail++; $display("FAIL reset_tile_idx: got %0d want 0", bus.tile_idx); end
        n_tests++; if (bus.result !== '0) begin n_fail++; $display("FAIL reset_result: got %0d want 0", bus.result); end
        n_tests++; if (bus.result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_result_valid: got %b want 0", bus.result_valid); end
        n_tests++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.err); end
        rst_n = 1'b1;
        tick();
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_basic();
        int first = -1;
        bit busy_bad = 1'b0;
        bit req_bad = 1'b0;
        logic signed [DATA_WIDTH-1:0] exp;
        tile_sums[0] = 16'sd100;
        tile_sums[1] = -16'sd20;
        tile_sums[2] = 16'sd5;
        tile_sums[3] = 16'sd15;
        bus.tile_gnt     = 1'b1;
        bus.result_ready = 1'b1;
        exp_q.push_back(16'sd110);
        start_op(4, 16'sd10, 1'b0);
        for (int c = 1; c <= 20; c++) begin
            if (bus.busy !== 1'b1) busy_bad = 1'b1;
            if (bus.tile_req !== (c <= 4)) req_bad = 1'b1;
            if (c <= 4 && bus.tile_idx !== TILE_W'(c - 1)) req_bad = 1'b1;
            if (bus.result_valid === 1'b1) begin
                first = c;
                break;
            end
            tick();
        end
        exp = exp_q.pop_front();
        n_tests++; if (first != 8) begin n_fail++; $display("FAIL basic_latency: got cycle %0d want 8", first); end
        n_tests++; if (busy_bad) begin n_fail++; $display("FAIL basic_busy: busy low during cycles 1..%0d, want high", first); end
        n_tests++; if (req_bad) begin n_fail++; $display("FAIL basic_tile_req: request/index sequence wrong, want req in 1..4 idx 0..3"); end
        n_tests++; if (bus.result !== exp) begin n_fail++; $display("FAIL basic_result: got %0d want %0d", bus.result, exp); end
        tick();
        n_tests++; if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_accept: busy=%b valid=%b want 0 0", bus.busy, bus.result_valid);
        end
        bus.tile_gnt = 1'b0;
    endtask

    task automatic test_stall();
        bit hold_bad = 1'b0;
        bit ok;
        int w;
        logic signed [DATA_WIDTH-1:0] exp;
        tile_sums[0] = 16'sd7;
        tile_sums[1] = -16'sd3;
        tile_sums[2] = 16'sd11;
        bus.tile_gnt     = 1'b0;
        bus.result_ready = 1'b1;
        exp_q.push_back(16'sd11);
        start_op(3, -16'sd4, 1'b0);
        for (int t = 0; t < 3; t++) begin
            for (int k = 0; k < 3; k++) begin
                bus.tile_gnt = (k == 2);
                if (bus.tile_req !== 1'b1 || bus.tile_idx !== TILE_W'(t)) hold_bad = 1'b1;
                tick();
            end
        end
        bus.tile_gnt = 1'b0;
        n_tests++; if (hold_bad) begin n_fail++; $display("FAIL stall_hold: tile_req/tile_idx not held while tile_gnt low"); end
        wait_result(20, w, ok);
        exp = exp_q.pop_front();
        n_tests++; if (!ok) begin n_fail++; $display("FAIL stall_timeout: no result_valid within 20 cycles"); end
        n_tests++; if (bus.result !== exp) begin n_fail++; $display("FAIL stall_result: got %0d want %0d", bus.result, exp); end
        tick();
    endtask

    task automatic test_saturate();
        logic signed [DATA_WIDTH-1:0] got;
        logic signed [DATA_WIDTH-1:0] exp;
        bit ok;
        tile_sums[0] = 16'sd30000;
        tile_sums[1] = 16'sd30000;
        exp_q.push_back(16'sd32767);
        run_one(2, 16'sd0, 1'b0, got, ok);
        exp = exp_q.pop_front();
        n_tests++; if (!ok || got !== exp) begin n_fail++; $display("FAIL sat_pos: got %0d want %0d", got, exp); end
        tile_sums[0] = -16'sd30000;
        tile_sums[1] = -16'sd30000;
        exp_q.push_back(16'sd0);
        run_one(2, 16'sd0, 1'b1, got, ok);
        exp = exp_q.pop_front();
        n_tests++; if (!ok || got !== exp) begin n_fail++; $display("FAIL sat_relu: got %0d want %0d", got, exp); end
        exp_q.push_back(-16'sd32768);
        run_one(2, 16'sd0, 1'b0, got, ok);
        exp = exp_q.pop_front();
        n_tests++; if (!ok || got !== exp) begin n_fail++; $display("FAIL sat_neg: got %0d want %0d", got, exp); end
    endtask

    task automatic test_zero_tiles();
        bit req_seen = 1'b0;
        bit stable_bad = 1'b0;
        logic signed [DATA_WIDTH-1:0] exp;
        bus.tile_gnt     = 1'b1;
        bus.result_ready = 1'b0;
        exp_q.push_back(-16'sd7);
        start_op(0, -16'sd7, 1'b0);
        if (bus.tile_req !== 1'b0) req_seen = 1'b1;
        n_tests++; if (bus.result_valid !== 1'b0) begin n_fail++; $display("FAIL zero_early_valid: got %b want 0 in cycle 1", bus.result_valid); end
        tick();
        exp = exp_q.pop_front();
        n_tests++; if (bus.result_valid !== 1'b1 || bus.result !== exp) begin
            n_fail++; $display("FAIL zero_result: valid=%b result=%0d want 1 %0d in cycle 2", bus.result_valid, bus.result, exp);
        end
        for (int k = 0; k < 5; k++) begin
            bus.start     = 1'b1;
            bus.num_tiles = TILE_W'(3);
            bus.bias      = 16'sd99;
            if (bus.result_valid !== 1'b1 || bus.result !== exp) stable_bad = 1'b1;
            if (bus.tile_req !== 1'b0) req_seen = 1'b1;
            tick();
        end
        bus.start = 1'b0;
        n_tests++; if (stable_bad || bus.result_valid !== 1'b1 || bus.result !== exp) begin
            n_fail++; $display("FAIL zero_hold: valid=%b result=%0d want 1 %0d held", bus.result_valid, bus.result, exp);
        end
        bus.result_ready = 1'b1;
        tick();
        bus.result_ready = 1'b0;
        n_tests++; if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL zero_accept: valid=%b busy=%b want 0 0", bus.result_valid, bus.busy);
        end
        n_tests++; if (bus.result !== exp) begin n_fail++; $display("FAIL zero_keep: got %0d want %0d", bus.result, exp); end
        n_tests++; if (req_seen) begin n_fail++; $display("FAIL zero_no_req: tile_req seen, want never"); end
        bus.tile_gnt = 1'b0;
    endtask

    task automatic test_reset_midop();
        bit ok;
        int w;
        logic signed [DATA_WIDTH-1:0] exp;
        tile_sums[0] = 16'sd50;
        tile_sums[1] = 16'sd60;
        bus.tile_gnt     = 1'b1;
        bus.result_ready = 1'b1;
        start_op(2, 16'sd0, 1'b0);
        tick();
        tick();
        n_tests++; if (bus.busy !== 1'b1 || bus.tile_req !== 1'b0) begin
            n_fail++; $display("FAIL midop_drain: busy=%b tile_req=%b want 1 0", bus.busy, bus.tile_req);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if ({bus.busy, bus.tile_req, bus.tile_idx, bus.result_valid, bus.err} !== '0) begin
            n_fail++; $display("FAIL midop_reset_ctrl: busy=%b req=%b idx=%0d valid=%b err=%b want all 0",
                               bus.busy, bus.tile_req, bus.tile_idx, bus.result_valid, bus.err);
        end
        n_tests++; if (bus.result !== '0) begin n_fail++; $display("FAIL midop_reset_result: got %0d want 0", bus.result); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.tile_gnt = 1'b0;
        tick();
        tick();
        n_tests++; if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL midop_stale: err=%b busy=%b want 1 0", bus.err, bus.busy);
        end
        tile_sums[0] = 16'sd42;
        exp_q.push_back(16'sd42);
        bus.tile_gnt = 1'b1;
        start_op(1, 16'sd0, 1'b0);
        n_tests++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL midop_err_clear: got %b want 0", bus.err); end
        wait_result(20, w, ok);
        exp = exp_q.pop_front();
        n_tests++; if (!ok || bus.result !== exp) begin n_fail++; $display("FAIL midop_result: got %0d want %0d", bus.result, exp); end
        tick();
        bus.tile_gnt = 1'b0;
    endtask

    task automatic test_protocol_err();
        bit ok;
        int w;
        logic signed [DATA_WIDTH-1:0] exp;
        bus.tile_gnt     = 1'b1;
        bus.result_ready = 1'b0;
        extra_d = 16'sd500;
        extra_req++;
        repeat (3) tick();
        n_tests++; if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL err_idle_sum: err=%b busy=%b want 1 0", bus.err, bus.busy);
        end
        tile_sums[0] = 16'sd40;
        tile_sums[1] = 16'sd2;
        exp_q.push_back(16'sd43);
        start_op(2, 16'sd1, 1'b0);
        n_tests++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL err_start_clear: got %b want 0", bus.err); end
        wait_result(20, w, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL err_timeout: no result_valid within 20 cycles"); end
        extra_d = 16'sd1000;
        extra_req++;
        repeat (3) tick();
        exp = exp_q.pop_front();
        n_tests++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL err_dup_sum: got %b want 1", bus.err); end
        n_tests++; if (bus.result_valid !== 1'b1 || bus.result !== exp) begin
            n_fail++; $display("FAIL err_result_intact: valid=%b result=%0d want 1 %0d", bus.result_valid, bus.result, exp);
        end
        bus.result_ready = 1'b1;
        tick();
        exp_q.push_back(16'sd5);
        start_op(0, 16'sd5, 1'b0);
        n_tests++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL err_next_clear: got %b want 0", bus.err); end
        wait_result(10, w, ok);
        exp = exp_q.pop_front();
        n_tests++; if (!ok || bus.result !== exp) begin n_fail++; $display("FAIL err_next_result: got %0d want %0d", bus.result, exp); end
        tick();
        bus.tile_gnt = 1'b0;
    endtask

    initial begin
        bus.start        = 1'b0;
        bus.num_tiles    = '0;
        bus.bias         = '0;
        bus.relu_en      = 1'b0;
        bus.tile_gnt     = 1'b0;
        bus.result_ready = 1'b0;
        for (int i = 0; i < MAX_TILES; i++) tile_sums[i] = '0;
        test_reset();
        test_basic();
        test_stall();
        test_saturate();
        test_zero_tiles();
        test_reset_midop();
        test_protocol_err();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
